cp0_param: RTL

Parametrised CP0 (system control coprocessor) for the MIPS32 core, replacing the fixed-configuration CP0. It holds:
- the Status, Cause, EPC, BadVAddr, Count and Compare registers;
- a configurable number of synchronised hardware interrupt lines and a prescaled Count/Compare timer.

It also generates the pipeline interrupt request and the exception/ERET redirect target for the fetch stage.

---
 rtl/cp0_param.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/cp0_param.sv
// Parametrised MIPS32 CP0: Status/Cause/EPC/BadVAddr plus synchronised hw interrupts.
// Define CP0_TIMER_EN to build the prescaled Count/Compare timer and the TI interrupt.
module cp0_param #(
  parameter int          NUM_HW_INT  = 6,
  parameter int          COUNT_DIV   = 2,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            reg_num,
  input  logic [1:0]            sel,
  input  logic                  wen,
  input  logic [31:0]           reg_in,
  output logic [31:0]           reg_out,
  input  logic                  exception,
  input  logic [4:0]            excode,
  input  logic                  is_delay_slot,
  input  logic [31:0]           pc,
  input  logic [31:0]           badvaddr_in,
  input  logic                  badvaddr_valid,
  input  logic                  eret,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic                  int_req,
  output logic                  status_exl,
  output logic [31:0]           exc_target
);

  localparam logic [4:0] R_BADVADDR = 5'd8;
  localparam logic [4:0] R_COUNT    = 5'd9;
  localparam logic [4:0] R_COMPARE  = 5'd11;
  localparam logic [4:0] R_STATUS   = 5'd12;
  localparam logic [4:0] R_CAUSE    = 5'd13;
  localparam logic [4:0] R_EPC      = 5'd14;

  if (NUM_HW_INT < 1 || NUM_HW_INT > 6) begin : g_bad_num_hw_int
    $error("cp0_param: NUM_HW_INT must be 1..6");
  end
  if (COUNT_DIV < 1) begin : g_bad_count_div
    $error("cp0_param: COUNT_DIV must be >= 1");
  end
  if (SYNC_STAGES < 0) begin : g_bad_sync_stages
    $error("cp0_param: SYNC_STAGES must be >= 0");
  end

  logic [7:0]            im_q, im_d;
  logic                  exl_q, exl_d;
  logic                  ie_q, ie_d;
  logic                  bd_q, bd_d;
  logic [4:0]            excode_q, excode_d;
  logic [1:0]            ip_sw_q, ip_sw_d;
  logic [NUM_HW_INT-1:0] ip_hw_q;
  logic [31:0]           epc_q, epc_d;
  logic [31:0]           bva_q, bva_d;
  logic [NUM_HW_INT-1:0] hw_sync;
  logic [5:0]            hw_pad;
  logic [7:0]            ip;
  logic                  ti;
  logic [31:0]           count_rd, compare_rd;
  logic                  wr_en;

  // MTC0 is dropped whenever an exception or ERET commits in the same cycle.
  assign wr_en = wen & (sel == 2'd0) & ~exception & ~eret;

  if (SYNC_STAGES > 0) begin : g_sync
    logic [NUM_HW_INT-1:0] sync_q [SYNC_STAGES];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
        sync_q[0] <= hw_int;
        for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end
    assign hw_sync = sync_q[SYNC_STAGES-1];
  end else begin : g_nosync
    assign hw_sync = hw_int;
  end

  always_comb begin
    hw_pad = '0;
    hw_pad[NUM_HW_INT-1:0] = ip_hw_q;
  end

  assign ip = {hw_pad[5] | ti, hw_pad[4:0], ip_sw_q};

`ifdef CP0_TIMER_EN
  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          ti_q, ti_d;
  logic          tick, wr_count, wr_compare;

  assign tick       = (presc_q == PW'(COUNT_DIV - 1));
  assign wr_count   = wr_en & (reg_num == R_COUNT);
  assign wr_compare = wr_en & (reg_num == R_COMPARE);

  // A Count write restarts the prescaler and suppresses the coincident tick.
  always_comb begin
    presc_d   = (wr_count | tick) ? '0 : presc_q + PW'(1);
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (wr_count) count_d = reg_in;
    else if (tick) count_d = count_q + 32'd1;
    if (wr_compare) begin
      compare_d = reg_in;
      ti_d      = 1'b0;
    end else if (tick && !wr_count && (count_q + 32'd1 == compare_q)) begin
      ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign ti         = ti_q;
  assign count_rd   = count_q;
  assign compare_rd = compare_q;
`else
  assign ti         = 1'b0;
  assign count_rd   = '0;
  assign compare_rd = '0;
`endif

  // Priority: exception, then ERET, then MTC0.
  always_comb begin
    im_d     = im_q;
    exl_d    = exl_q;
    ie_d     = ie_q;
    bd_d     = bd_q;
    excode_d = excode_q;
    ip_sw_d  = ip_sw_q;
    epc_d    = epc_q;
    bva_d    = bva_q;
    if (exception) begin
      exl_d    = 1'b1;
      excode_d = excode;
      if (!exl_q) begin
        epc_d = is_delay_slot ? pc - 32'd4 : pc;
        bd_d  = is_delay_slot;
      end
      if (badvaddr_valid) bva_d = badvaddr_in;
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (wr_en) begin
      case (reg_num)
        R_STATUS: begin
          im_d  = reg_in[15:8];
          exl_d = reg_in[1];
          ie_d  = reg_in[0];
        end
        R_CAUSE: ip_sw_d = reg_in[9:8];
        R_EPC:   epc_d   = reg_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q     <= '0;
      exl_q    <= 1'b0;
      ie_q     <= 1'b0;
      bd_q     <= 1'b0;
      excode_q <= '0;
      ip_sw_q  <= '0;
      ip_hw_q  <= '0;
      epc_q    <= '0;
      bva_q    <= '0;
    end else begin
      im_q     <= im_d;
      exl_q    <= exl_d;
      ie_q     <= ie_d;
      bd_q     <= bd_d;
      excode_q <= excode_d;
      ip_sw_q  <= ip_sw_d;
      ip_hw_q  <= hw_sync;
      epc_q    <= epc_d;
      bva_q    <= bva_d;
    end
  end

  always_comb begin
    reg_out = '0;
    if (sel == 2'd0) begin
      case (reg_num)
        R_BADVADDR: reg_out = bva_q;
        R_COUNT:    reg_out = count_rd;
        R_COMPARE:  reg_out = compare_rd;
        R_STATUS:   reg_out = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
        R_CAUSE:    reg_out = {bd_q, ti, 14'b0, ip, 1'b0, excode_q, 2'b0};
        R_EPC:      reg_out = epc_q;
        default:    reg_out = '0;
      endcase
    end
  end

  assign int_req    = ie_q & ~exl_q & (|(ip & im_q));
  assign status_exl = exl_q;
  assign exc_target = exception ? EXC_VECTOR : epc_q;

endmodule
